// File: rtl/memory_access.sv
// MEM pipeline stage: runs load/store transactions on the data-memory port, formats load data, forwards ALU results.
// Non-mem ops retire one cycle after accept; mem ops hold o_ex_rdy low until gnt (store) or rvalid (load).
module memory_access #(
  parameter int         N        = 32,
  parameter logic [6:0] OP_LOAD  = 7'b0000011,
  parameter logic [6:0] OP_STORE = 7'b0100011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ex_vld,
  output logic         o_ex_rdy,
  input  logic [N-1:0] i_alu_result,
  input  logic [N-1:0] i_rs2_data,
  input  logic [4:0]   i_rd,
  input  logic [6:0]   i_opcode,
  input  logic [2:0]   i_funct3,
  output logic         o_dmem_req,
  output logic         o_dmem_we,
  output logic [N-1:0] o_dmem_addr,
  output logic [N-1:0] o_dmem_wdata,
  output logic [3:0]   o_dmem_be,
  input  logic         i_dmem_gnt,
  input  logic         i_dmem_rvalid,
  input  logic [N-1:0] i_dmem_rdata,
  output logic [4:0]   o_rd,
  output logic [6:0]   o_opcode,
  output logic [N-1:0] o_wb_data,
  output logic         o_mem_vld,
  output logic         o_mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t       state;
  logic [2:0]   f3_q;
  logic [1:0]   a_q;
  logic [4:0]   rd_q;
  logic [6:0]   op_q;

  logic         accept, is_load, is_store, is_mem, f3_ok, aligned, legal;
  logic [1:0]   a;
  logic [3:0]   be_n;
  logic [N-1:0] wdata_n;

  assign o_ex_rdy = rst_n && (state == IDLE);
  assign accept   = i_ex_vld && o_ex_rdy;

  always_comb begin
    a        = i_alu_result[1:0];
    is_load  = (i_opcode == OP_LOAD);
    is_store = (i_opcode == OP_STORE);
    is_mem   = is_load || is_store;
    f3_ok    = 1'b0;
    aligned  = 1'b0;
    case (i_funct3)
      3'b000: begin f3_ok = 1'b1;    aligned = 1'b1;     end
      3'b001: begin f3_ok = 1'b1;    aligned = ~a[0];    end
      3'b010: begin f3_ok = 1'b1;    aligned = (a == 2'b00); end
      3'b100: begin f3_ok = is_load; aligned = 1'b1;     end
      3'b101: begin f3_ok = is_load; aligned = ~a[0];    end
      default: begin f3_ok = 1'b0;   aligned = 1'b0;     end
    endcase
    legal   = f3_ok && aligned;
    be_n    = 4'b1111;
    wdata_n = i_rs2_data;
    if (is_store) begin
      case (i_funct3[1:0])
        2'b00: begin be_n = 4'b0001 << a; wdata_n = {4{i_rs2_data[7:0]}};  end
        2'b01: begin be_n = 4'b0011 << a; wdata_n = {2{i_rs2_data[15:0]}}; end
        default: ;
      endcase
    end
  end

  // Lane select uses the byte offset captured at accept, not the live address.
  function automatic logic [N-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [N-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{(N-8){b[7]}}, b};
      3'b001:  fmt_load = {{(N-16){h[15]}}, h};
      3'b100:  fmt_load = {{(N-8){1'b0}}, b};
      3'b101:  fmt_load = {{(N-16){1'b0}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      f3_q         <= '0;
      a_q          <= '0;
      rd_q         <= '0;
      op_q         <= '0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      o_rd         <= '0;
      o_opcode     <= '0;
      o_wb_data    <= '0;
      o_mem_vld    <= 1'b0;
      o_mem_err    <= 1'b0;
    end else begin
      o_mem_vld <= 1'b0;
      o_mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q <= i_funct3;
            a_q  <= a;
            rd_q <= i_rd;
            op_q <= i_opcode;
            if (!is_mem) begin
              o_mem_vld <= 1'b1;
              o_rd      <= i_rd;
              o_opcode  <= i_opcode;
              o_wb_data <= i_alu_result;
            end else if (legal) begin
              state        <= REQ;
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= is_store;
              o_dmem_addr  <= {i_alu_result[N-1:2], 2'b00};
              o_dmem_be    <= be_n;
              o_dmem_wdata <= wdata_n;
            end else begin
              o_mem_err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            o_dmem_req <= 1'b0;
            o_dmem_we  <= 1'b0;
            if (o_dmem_we) begin
              state     <= IDLE;
              o_mem_vld <= 1'b1;
              o_rd      <= rd_q;
              o_opcode  <= op_q;
              o_wb_data <= '0;
            end else begin
              state <= RSP;
            end
          end
        end
        RSP: begin
          if (i_dmem_rvalid) begin
            state     <= IDLE;
            o_mem_vld <= 1'b1;
            o_rd      <= rd_q;
            o_opcode  <= op_q;
            o_wb_data <= fmt_load(f3_q, a_q, i_dmem_rdata);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected retirements are queued at stimulus time and popped by a monitor.
module tb_memory_access;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_vld = 1'b0, ex_rdy;
  logic [31:0] alu_result = '0, rs2_data = '0;
  logic [4:0]  rd = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  o_rd;
  logic [6:0]  o_opcode;
  logic [31:0] wb_data;
  logic        mem_vld, mem_err;

  typedef struct {
    logic        err;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [31:0] wb;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .i_ex_vld(ex_vld), .o_ex_rdy(ex_rdy),
    .i_alu_result(alu_result), .i_rs2_data(rs2_data), .i_rd(rd), .i_opcode(opcode),
    .i_funct3(funct3), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be), .i_dmem_gnt(dmem_gnt),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata), .o_rd(o_rd), .o_opcode(o_opcode),
    .o_wb_data(wb_data), .o_mem_vld(mem_vld), .o_mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [4:0] r, input logic [6:0] op,
                              input logic [31:0] wb);
    exp_t e;
    e.err = err; e.rd = r; e.op = op; e.wb = wb;
    return e;
  endfunction

  // Reference load formatter: shift the addressed lane down, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return (s[7]  ? 32'hFFFF_FF00 : 32'h0) | (s & 32'hFF);
      3'b001:  return (s[15] ? 32'hFFFF_0000 : 32'h0) | (s & 32'hFFFF);
      3'b100:  return s & 32'hFF;
      3'b101:  return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && (mem_vld || mem_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_retire", {mem_err, mem_vld}, 0);
      end else begin
        mon_e = q.pop_front();
        chk("sb_err", mem_err, mon_e.err);
        chk("sb_vld", mem_vld, !mon_e.err);
        if (!mon_e.err) begin
          chk("sb_rd", o_rd, mon_e.rd);
          chk("sb_op", o_opcode, mon_e.op);
          chk("sb_wb", wb_data, mon_e.wb);
        end
      end
    end
  end

  // Entered and left just after a rising edge; waits (bounded) for the stage to be ready.
  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] r,
                       input logic [6:0] op, input logic [2:0] f3);
    int n = 0;
    while (!ex_rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ex_rdy) chk("rdy_timeout", 0, 1);
    alu_result = alu; rs2_data = rs2; rd = r; opcode = op; funct3 = f3; ex_vld = 1'b1;
    @(posedge clk); #1;
    ex_vld = 1'b0;
  endtask

  // Plays the memory side of one accepted load/store and checks the request fields.
  task automatic do_mem(input logic st, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int gw, input int rw,
                        input logic [31:0] rdata, input exp_t e);
    for (int i = 0; i <= gw; i++) begin
      @(negedge clk);
      chk("req", dmem_req, 1);
      chk("we", dmem_we, st);
      chk("addr", dmem_addr, addr);
      chk("be", dmem_be, be);
      if (st) chk("wdata", dmem_wdata, wd);
      chk("rdy_busy", ex_rdy, 0);
      chk("vld_early", mem_vld, 0);
      if (i == gw) dmem_gnt = 1'b1;
    end
    if (st) q.push_back(e);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    if (!st) begin
      for (int j = 0; j < rw - 1; j++) begin
        @(negedge clk);
        chk("req_rsp", dmem_req, 0);
        chk("rdy_rsp", ex_rdy, 0);
        chk("vld_rsp", mem_vld, 0);
        @(posedge clk); #1;
      end
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      q.push_back(e);
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
    end
    @(negedge clk);
    chk("retire_vld", mem_vld, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdw, rs2v, addr;
    logic [2:0]  f3;
    logic [2:0]  f3_tab[5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    // Reset values
    #12;
    chk("rst_rdy", ex_rdy, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wb", wb_data, 0);
    chk("rst_vld", {mem_vld, mem_err}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    #1; chk("rdy_after_rst", ex_rdy, 1);

    // 1: ADD passes through in one cycle
    q.push_back(mk(0, 5'd5, OP_ADD, 32'h1234));
    issue(32'h1234, 0, 5'd5, OP_ADD, 3'b000);
    @(negedge clk);
    chk("add_vld", mem_vld, 1);
    chk("add_noreq", dmem_req, 0);
    @(negedge clk);
    chk("add_vld_drop", mem_vld, 0);
    @(posedge clk); #1;

    // 2: SB to 0x103, grant after 2 cycles
    issue(32'h103, 32'hAABBCC7F, 5'd0, OP_STORE, 3'b000);
    do_mem(1, 32'h100, 4'b1000, 32'h7F7F7F7F, 2, 0, 0, mk(0, 5'd0, OP_STORE, 0));

    // SH and SW lane placement
    issue(32'h402, 32'h1234ABCD, 5'd1, OP_STORE, 3'b001);
    do_mem(1, 32'h400, 4'b1100, 32'hABCDABCD, 0, 0, 0, mk(0, 5'd1, OP_STORE, 0));
    issue(32'h404, 32'hDEADBEEF, 5'd2, OP_STORE, 3'b010);
    do_mem(1, 32'h404, 4'b1111, 32'hDEADBEEF, 1, 0, 0, mk(0, 5'd2, OP_STORE, 0));

    // 3: byte/half loads from 0x202
    issue(32'h202, 0, 5'd3, OP_LOAD, 3'b000);
    do_mem(0, 32'h200, 4'hF, 0, 1, 1, 32'h12803456, mk(0, 5'd3, OP_LOAD, 32'hFFFFFF80));
    issue(32'h202, 0, 5'd4, OP_LOAD, 3'b100);
    do_mem(0, 32'h200, 4'hF, 0, 0, 2, 32'h12803456, mk(0, 5'd4, OP_LOAD, 32'h00000080));
    issue(32'h202, 0, 5'd6, OP_LOAD, 3'b001);
    do_mem(0, 32'h200, 4'hF, 0, 0, 1, 32'h12803456, mk(0, 5'd6, OP_LOAD, 32'h00001280));

    // 4: misaligned LW, then illegal-funct3 store and misaligned SH
    q.push_back(mk(1, 0, 0, 0));
    issue(32'h6, 0, 5'd7, OP_LOAD, 3'b010);
    @(negedge clk);
    chk("mis_err", mem_err, 1);
    chk("mis_vld", mem_vld, 0);
    chk("mis_req", dmem_req, 0);
    chk("mis_rdy", ex_rdy, 1);
    @(negedge clk);
    chk("mis_err_drop", mem_err, 0);
    chk("mis_req2", dmem_req, 0);
    @(posedge clk); #1;
    q.push_back(mk(1, 0, 0, 0));
    issue(32'h8, 0, 5'd8, OP_STORE, 3'b100);
    q.push_back(mk(1, 0, 0, 0));
    issue(32'h9, 0, 5'd8, OP_STORE, 3'b001);
    @(negedge clk);
    chk("illegal_req", dmem_req, 0);
    @(posedge clk); #1;

    // 5: three ALU ops back to back, then LW with immediate grant and rvalid 3 cycles later
    for (int k = 0; k < 3; k++) q.push_back(mk(0, 5'(10 + k), OP_ADD, 32'h100 * (k + 1)));
    for (int k = 0; k < 3; k++) issue(32'h100 * (k + 1), 0, 5'(10 + k), OP_ADD, 3'b000);
    issue(32'h500, 0, 5'd13, OP_LOAD, 3'b010);
    do_mem(0, 32'h500, 4'hF, 0, 0, 3, 32'hCAFEF00D, mk(0, 5'd13, OP_LOAD, 32'hCAFEF00D));

    // 6: reset while waiting for rvalid; late rvalid must be ignored
    issue(32'h300, 0, 5'd14, OP_LOAD, 3'b010);
    @(negedge clk); dmem_gnt = 1'b1;
    @(posedge clk); #1; dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_rdy", ex_rdy, 0);
    chk("mrst_req", dmem_req, 0);
    chk("mrst_outs", {mem_vld, mem_err, dmem_we, dmem_be}, 0);
    chk("mrst_wb", wb_data, 0);
    chk("mrst_rd", {o_rd, o_opcode}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
    @(posedge clk); #1; dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_vld", mem_vld, 0);
    chk("late_rvalid_rdy", ex_rdy, 1);
    @(posedge clk); #1;
    q.push_back(mk(0, 5'd15, OP_ADD, 32'h77));
    issue(32'h77, 0, 5'd15, OP_ADD, 3'b000);
    @(negedge clk);
    chk("post_rst_vld", mem_vld, 1);
    @(posedge clk); #1;

    // Randomised legal loads against the reference formatter
    for (int k = 0; k < 8; k++) begin
      f3   = f3_tab[$urandom_range(4)];
      addr = $urandom & 32'h0000_0FFF;
      if (f3[1:0] == 2'b01) addr[0] = 1'b0;
      if (f3 == 3'b010) addr[1:0] = 2'b00;
      rdw  = $urandom;
      rs2v = $urandom;
      issue(addr, rs2v, 5'(k + 16), OP_LOAD, f3);
      do_mem(0, {addr[31:2], 2'b00}, 4'hF, 0, $urandom_range(2), $urandom_range(1, 3), rdw,
             mk(0, 5'(k + 16), OP_LOAD, model_load(f3, addr[1:0], rdw)));
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
